// File: rtl/nabp_mapper_sequencer.sv
// Steps the projection-line mapper through every angle: fetch LUT words,
// load them, kick the mapper, then issue one line of shifts per angle.
module nabp_mapper_sequencer #(
    parameter int LINE_SIZE   = 256,
    parameter int NUM_ANGLES  = 180,
    parameter int ANGLE_WIDTH = 8,
    parameter int ACCU_WIDTH  = 24
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   hold,
    output logic [ANGLE_WIDTH-1:0] lut_addr,
    input  logic [ACCU_WIDTH-1:0]  lut_init,
    input  logic [ACCU_WIDTH-1:0]  lut_base,
    output logic [ACCU_WIDTH-1:0]  mp_accu_init,
    output logic [ACCU_WIDTH-1:0]  mp_accu_base,
    output logic                   sh_kick,
    output logic                   sh_shift_en,
    output logic                   sh_done,
    output logic [ANGLE_WIDTH-1:0] angle,
    output logic                   busy,
    output logic                   done
);

    localparam int CNT_W = $clog2(LINE_SIZE) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_SIZE - 1);
    localparam logic [ANGLE_WIDTH-1:0] LAST_ANG = ANGLE_WIDTH'(NUM_ANGLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_KICK,
        S_SHIFT,
        S_LDONE
    } state_t;

    state_t                 state_q;
    logic [ANGLE_WIDTH-1:0] angle_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [ACCU_WIDTH-1:0]  init_q;
    logic [ACCU_WIDTH-1:0]  base_q;
    logic                   kick_q;
    logic                   ldone_q;
    logic                   done_q;
    logic                   busy_q;
    logic                   abort_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            angle_q <= '0;
            cnt_q   <= '0;
            init_q  <= '0;
            base_q  <= '0;
            kick_q  <= 1'b0;
            ldone_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            kick_q  <= 1'b0;
            ldone_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_FETCH;
                        angle_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_KICK;
                        init_q  <= lut_init;
                        base_q  <= lut_base;
                        kick_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                S_KICK: begin
                    // The kick is already visible, so close the line properly
                    if (abort) begin
                        state_q <= S_LDONE;
                        ldone_q <= 1'b1;
                        abort_q <= 1'b1;
                    end else begin
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        state_q <= S_LDONE;
                        ldone_q <= 1'b1;
                        abort_q <= 1'b1;
                        cnt_q   <= '0;
                    end else if (!hold) begin
                        if (cnt_q == LAST_CNT) begin
                            state_q <= S_LDONE;
                            ldone_q <= 1'b1;
                            done_q  <= (angle_q == LAST_ANG);
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_LDONE: begin
                    abort_q <= 1'b0;
                    if (abort_q || abort || angle_q == LAST_ANG) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_FETCH;
                        angle_q <= angle_q + ANGLE_WIDTH'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign lut_addr     = angle_q;
    assign angle        = angle_q;
    assign mp_accu_init = init_q;
    assign mp_accu_base = base_q;
    assign sh_kick      = kick_q;
    assign sh_done      = ldone_q;
    assign done         = done_q;
    assign busy         = busy_q;
    assign sh_shift_en  = (state_q == S_SHIFT) && !hold;

endmodule

// File: doc/nabp_mapper_sequencer.md
# nabp_mapper_sequencer

Sequences the projection-line mapper across all projection angles. For each angle it fetches the mapper accumulator initial value and step from an external angle lookup table, then drives the mapper's kick / shift-enable / done handshake for exactly one projection line of shifts. It replaces hand-driven shifter strobes and sits between the top-level state control and the mapper plus line-buffer datapath.

## Interface

Parameters:
- LINE_SIZE, 256: shifts per angle (projection line size)
- NUM_ANGLES, 180: angles per run
- ANGLE_WIDTH, 8: width of the angle index
- ACCU_WIDTH, 24: width of the mapper accumulator init/base words (signed fixed point, passed through unmodified)

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a run; one-cycle pulse, sampled in IDLE only
- abort  in  1  synchronous abort, honoured in any non-IDLE state
- hold  in  1  downstream stall; suppresses shifting while high
- lut_addr  out  ANGLE_WIDTH  angle index presented to the lookup table
- lut_init  in  ACCU_WIDTH  lookup init value, valid 1 cycle after lut_addr
- lut_base  in  ACCU_WIDTH  lookup step value, valid 1 cycle after lut_addr
- mp_accu_init  out  ACCU_WIDTH  registered mapper initial accumulator
- mp_accu_base  out  ACCU_WIDTH  registered mapper accumulator step
- sh_kick  out  1  mapper start strobe
- sh_shift_en  out  1  mapper advance strobe
- sh_done  out  1  mapper end-of-line strobe
- angle  out  ANGLE_WIDTH  current angle index
- busy  out  1  run in progress
- done  out  1  one-cycle end-of-run pulse

## Operation

- States:
  - IDLE
  - FETCH: lut_addr = angle
  - LOAD: latch lut_init/lut_base into mp_accu_init/mp_accu_base
  - KICK: sh_kick = 1
  - SHIFT: issue shifts
  - LINE_DONE: sh_done = 1
- Transitions:
  - IDLE -> FETCH on start; angle cleared to 0.
  - FETCH -> LOAD -> KICK -> SHIFT unconditionally.
  - In SHIFT, sh_shift_en = !hold. This is the only combinational input-to-output path.
  - shift_cnt (width clog2(LINE_SIZE)+1) increments on each cycle with sh_shift_en = 1. After the shift with shift_cnt == LINE_SIZE-1, go to LINE_DONE.
  - LINE_DONE: if angle == NUM_ANGLES-1, assert done in the same cycle and go to IDLE. Otherwise angle increments and go to FETCH.
- mp_accu_init and mp_accu_base change only in LOAD. They are stable from KICK through LINE_DONE, so the mapper samples the init value on kick.
- busy = (state != IDLE).
- start while busy is ignored.
- abort:
  - In SHIFT: next state is LINE_DONE for one cycle (sh_done = 1, done = 0), then IDLE.
  - In FETCH, LOAD or KICK: go directly to IDLE. If abort is raised in KICK, the mapper sees that kick; the next cycle is IDLE with no sh_done. Therefore abort in KICK is treated as abort in SHIFT (it routes through LINE_DONE).
- abort has priority over the SHIFT count completing.
- Simultaneous hold and final count: no shift occurs and the count does not advance.

## Timing

- Reset values: all outputs 0; state IDLE; angle 0; shift_cnt 0.
- Reset asserted mid-run clears everything immediately. No sh_done is emitted, and the mapper is reset by the same reset_n.
- Start sampled at cycle 0: FETCH at 1, LOAD at 2, KICK at 3, first sh_shift_en at 4.
- Per angle with no hold: LINE_SIZE + 4 cycles.
- Full run: NUM_ANGLES × (LINE_SIZE + 4) cycles; done is high in the last one.
- Each held cycle extends SHIFT by exactly one cycle.
- sh_kick, sh_done and done are exactly one cycle wide.
- sh_kick and sh_shift_en are never high together.

## Test plan

All scenarios use LINE_SIZE=4, NUM_ANGLES=3, and a LUT model returning init = 100 + angle and base = 10 × angle.

- Nominal: start pulse, hold = 0.
  - 3 kicks at cycles 3, 11 and 19.
  - Exactly 4 shift_en pulses per angle.
  - mp_accu_init = 100, 101, 102 and mp_accu_base = 0, 10, 20 at each kick.
  - done at cycle 24; busy high for cycles 1–24.
- Hold: hold = 1 for 3 cycles during the 2nd shift of angle 1.
  - Still exactly 4 shift_en pulses for that angle.
  - done delayed by 3 cycles, to cycle 27.
- Abort in SHIFT at angle 1 after 2 shifts.
  - Next cycle sh_done = 1, done = 0; then IDLE, busy = 0.
  - A new start afterwards begins at angle 0.
- Abort in LOAD: IDLE next cycle, no sh_kick, no sh_done.
- Abort in KICK: LINE_DONE next cycle with sh_done = 1, then IDLE; no shift_en, done = 0.
- Start while busy plus async reset mid-SHIFT.
  - The extra start has no effect on timing.
  - reset_n low zeroes all outputs without a clock edge; the run restarts cleanly on the next start.
